// File: rtl/fport_frame_tx.sv
// FPort control-frame transmitter: snapshots channels/flags/rssi, then feeds a
// byte-wide uart_tx with the delimited, checksummed frame. Define FPORT_TX_STUFF_EN for 7E/7D byte stuffing.
module fport_frame_tx #(
  parameter logic [7:0] LEN_BYTE  = 8'h19,
  parameter logic [7:0] TYPE_BYTE = 8'h00
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         send,
  input  logic [175:0] channels,
  input  logic [7:0]   flags,
  input  logic [7:0]   rssi,
  input  logic         tx_idle,
  output logic         tx_send,
  output logic [7:0]   tx_data,
  output logic         busy,
  output logic         frame_done
);

  typedef enum logic [2:0] {IDLE, LOAD, EMIT, WAIT_START, WAIT_DONE, DONE} state_t;

  state_t         state;
  logic [175:0]   ch_reg;
  logic [7:0]     flags_reg;
  logic [7:0]     rssi_reg;
  logic [7:0]     sum;
  logic [4:0]     idx;
  logic           esc_pending;

  logic [7:0]     payload;
  logic [7:0]     raw_byte;
  logic [8:0]     sum_wide;
  logic [7:0]     sum_next;
  logic           needs_stuff;

  always_comb begin
    payload = 8'h00;
    for (int b = 0; b < 22; b++) begin
      if (idx == 5'(b + 3)) payload = ch_reg[8*b +: 8];
    end
  end

  // Logical (unstuffed) byte for the current index; slot 27 is the checksum.
  always_comb begin
    case (idx)
      5'd0, 5'd28: raw_byte = 8'h7E;
      5'd1:        raw_byte = LEN_BYTE;
      5'd2:        raw_byte = TYPE_BYTE;
      5'd25:       raw_byte = flags_reg;
      5'd26:       raw_byte = rssi_reg;
      5'd27:       raw_byte = 8'hFF - sum;
      default:     raw_byte = payload;
    endcase
  end

  // End-around-carry accumulation: the carry out of bit 7 is folded back in.
  always_comb begin
    sum_wide = {1'b0, sum} + {1'b0, raw_byte};
    sum_next = sum_wide[7:0] + {7'b0, sum_wide[8]};
  end

`ifdef FPORT_TX_STUFF_EN
  assign needs_stuff = (idx != 5'd0) && (idx != 5'd28) &&
                       ((raw_byte == 8'h7E) || (raw_byte == 8'h7D));
`else
  assign needs_stuff = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      tx_send     <= 1'b0;
      tx_data     <= 8'h00;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      sum         <= 8'h00;
      idx         <= 5'd0;
      esc_pending <= 1'b0;
      ch_reg      <= '0;
      flags_reg   <= 8'h00;
      rssi_reg    <= 8'h00;
    end else begin
      tx_send    <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (send) begin
            ch_reg    <= channels;
            flags_reg <= flags;
            rssi_reg  <= rssi;
            busy      <= 1'b1;
            state     <= LOAD;
          end
        end
        LOAD: begin
          idx         <= 5'd0;
          sum         <= 8'h00;
          esc_pending <= 1'b0;
          state       <= EMIT;
        end
        EMIT: begin
          if (tx_idle) begin
            tx_send <= 1'b1;
            state   <= WAIT_START;
            // The checksum only absorbs each logical byte once, on its first wire byte.
            if (esc_pending) begin
              tx_data     <= raw_byte ^ 8'h20;
              esc_pending <= 1'b0;
            end else begin
              if (needs_stuff) begin
                tx_data     <= 8'h7D;
                esc_pending <= 1'b1;
              end else begin
                tx_data <= raw_byte;
              end
              if (idx >= 5'd1 && idx <= 5'd26) sum <= sum_next;
            end
          end
        end
        WAIT_START: begin
          if (!tx_idle) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (tx_idle) begin
            if (esc_pending) begin
              state <= EMIT;
            end else if (idx == 5'd28) begin
              busy       <= 1'b0;
              frame_done <= 1'b1;
              state      <= DONE;
            end else begin
              idx   <= idx + 5'd1;
              state <= EMIT;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fport_frame_tx.sv
// Randomized bench for fport_frame_tx: a behavioural uart responder captures
// wire bytes, and a frame model built from the FPort framing rules supplies the expected bytes.
module tb_fport_frame_tx;

  typedef logic [7:0] bq_t[$];

  logic         clock = 1'b0;
  logic         reset;
  logic         send;
  logic [175:0] channels;
  logic [7:0]   flags;
  logic [7:0]   rssi;
  logic         tx_idle;
  logic         tx_send;
  logic [7:0]   tx_data;
  logic         busy;
  logic         frame_done;

  int   n_checks = 0;
  int   n_errs = 0;
  int   fd_count = 0;
  int   consec_err = 0;
  int   uart_delay = 0;
  bit   prev_send = 1'b0;
  bq_t  got;

  fport_frame_tx dut (
    .clock(clock), .reset(reset), .send(send), .channels(channels),
    .flags(flags), .rssi(rssi), .tx_idle(tx_idle), .tx_send(tx_send),
    .tx_data(tx_data), .busy(busy), .frame_done(frame_done)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // uart_tx stand-in: accepts a byte, goes busy for a few cycles, then idle again.
  initial begin
    tx_idle = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      if (tx_send) begin
        int n;
        got.push_back(tx_data);
        tx_idle = 1'b0;
        n = (uart_delay == 0) ? int'($urandom_range(1, 4)) : uart_delay;
        repeat (n) @(posedge clock);
        #1;
        tx_idle = 1'b1;
      end
    end
  end

  always @(negedge clock) begin
    if (frame_done) fd_count++;
    if (tx_send && prev_send) consec_err++;
    prev_send = tx_send;
  end

  // Expected wire bytes: delimiters, header, payload, folded checksum, optional stuffing.
  task automatic buildFrame(input logic [175:0] ch, input logic [7:0] fl, input logic [7:0] rs,
                            output bq_t q);
    int raw[29];
    int s;
    raw[0] = 8'h7E; raw[1] = 8'h19; raw[2] = 8'h00;
    for (int k = 0; k < 22; k++) raw[3 + k] = int'(ch[8*k +: 8]);
    raw[25] = int'(fl); raw[26] = int'(rs);
    s = 0;
    for (int i = 1; i <= 26; i++) begin
      s = s + raw[i];
      if (s > 255) s = s - 255;
    end
    raw[27] = 255 - s;
    raw[28] = 8'h7E;
    q.delete();
    for (int i = 0; i < 29; i++) begin
`ifdef FPORT_TX_STUFF_EN
      if (i >= 1 && i <= 27 && (raw[i] == 8'h7E || raw[i] == 8'h7D)) begin
        q.push_back(8'h7D);
        q.push_back(8'(raw[i] ^ 8'h20));
      end else
`endif
        q.push_back(8'(raw[i]));
    end
  endtask

  task automatic applyStimulus(input logic [175:0] ch, input logic [7:0] fl, input logic [7:0] rs);
    channels = ch;
    flags    = fl;
    rssi     = rs;
    send     = 1'b1;
  endtask

  function automatic logic [175:0] randChannels();
    logic [175:0] c;
    for (int b = 0; b < 22; b++) begin
      case ($urandom_range(0, 7))
        0:       c[8*b +: 8] = 8'h7E;
        1:       c[8*b +: 8] = 8'h7D;
        default: c[8*b +: 8] = 8'($urandom_range(0, 255));
      endcase
    end
    return c;
  endfunction

  task automatic runFrame(input string name, input logic [175:0] ch, input logic [7:0] fl,
                          input logic [7:0] rs, input bit repulse, output bq_t captured);
    bq_t exp;
    int  fd0, lat, cyc;
    bit  busy_ok, done, p3, p20;
    buildFrame(ch, fl, rs, exp);
    got.delete();
    fd0 = fd_count; busy_ok = 1'b1; lat = -1; done = 1'b0; p3 = 1'b0; p20 = 1'b0; cyc = 0;
    applyStimulus(ch, fl, rs);
    while (!done && cyc < 3000) begin
      @(posedge clock);
      #2;
      cyc++;
      send = 1'b0;
      // Scramble the live inputs; the frame must come from the snapshot.
      if (cyc == 1) begin
        channels = randChannels();
        flags = 8'($urandom_range(0, 255));
        rssi = 8'($urandom_range(0, 255));
      end
      if (lat < 0 && got.size() > 0) lat = cyc;
      if (repulse && !p3 && got.size() == 3) begin send = 1'b1; p3 = 1'b1; end
      if (repulse && !p20 && got.size() == 20) begin send = 1'b1; p20 = 1'b1; end
      if (frame_done) begin
        done = 1'b1;
        checkOutput({name, " busy_at_done"}, busy, 1'b0);
        if (repulse) send = 1'b1;
      end else if (!busy) begin
        busy_ok = 1'b0;
      end
    end
    @(posedge clock);
    #2;
    send = 1'b0;
    repeat (20) @(posedge clock);
    #2;
    checkOutput({name, " frame_done_seen"}, done, 1'b1);
    checkOutput({name, " busy_held"}, busy_ok, 1'b1);
    checkOutput({name, " first_send_latency_ok"}, (lat >= 1 && lat <= 3), 1'b1);
    checkOutput({name, " byte_count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      if (i < got.size()) checkOutput($sformatf("%s byte%0d", name, i), got[i], exp[i]);
    end
    checkOutput({name, " frame_done_pulses"}, fd_count - fd0, 1);
    checkOutput({name, " busy_after"}, busy, 1'b0);
    captured = got;
  endtask

  task automatic resetMidFrame();
    int cyc, sz, fd0;
    got.delete();
    uart_delay = 4;
    applyStimulus('0, 8'h00, 8'h64);
    cyc = 0;
    while (got.size() < 11 && cyc < 2000) begin
      @(posedge clock);
      #2;
      cyc++;
      send = 1'b0;
    end
    checkOutput("rst reached_byte10", got.size(), 11);
    // One cycle later the DUT sits in WAIT_DONE of byte 10 with uart busy.
    @(posedge clock);
    #2;
    reset = 1'b1;
    @(posedge clock);
    #2;
    checkOutput("rst tx_send_low", tx_send, 1'b0);
    checkOutput("rst busy_low", busy, 1'b0);
    checkOutput("rst frame_done_low", frame_done, 1'b0);
    reset = 1'b0;
    sz = got.size();
    fd0 = fd_count;
    repeat (40) @(posedge clock);
    #2;
    checkOutput("rst no_more_bytes", got.size(), sz);
    checkOutput("rst no_frame_done", fd_count - fd0, 0);
    uart_delay = 0;
  endtask

  initial begin
    bq_t cap;
    reset = 1'b1; send = 1'b0; channels = '0; flags = 8'h00; rssi = 8'h00;
    repeat (3) @(posedge clock);
    #2;
    checkOutput("reset tx_send", tx_send, 1'b0);
    checkOutput("reset tx_data", tx_data, 8'h00);
    checkOutput("reset busy", busy, 1'b0);
    checkOutput("reset frame_done", frame_done, 1'b0);
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #2;

    runFrame("zero", '0, 8'h00, 8'h64, 1'b0, cap);
    if (cap.size() > 27) checkOutput("zero crc", cap[27], 8'h82);
    runFrame("fold", '0, 8'hFF, 8'hFF, 1'b0, cap);
    if (cap.size() > 27) checkOutput("fold crc", cap[27], 8'hE6);
    runFrame("rssi7e", '0, 8'h00, 8'h7E, 1'b0, cap);
`ifdef FPORT_TX_STUFF_EN
    checkOutput("rssi7e wire_len", cap.size(), 30);
`else
    checkOutput("rssi7e wire_len", cap.size(), 29);
    if (cap.size() > 26) checkOutput("rssi7e raw_slot", cap[26], 8'h7E);
`endif
    runFrame("repulse", randChannels(), 8'h7D, 8'h11, 1'b1, cap);
    runFrame("after_repulse", randChannels(), 8'h3C, 8'h7E, 1'b0, cap);
    resetMidFrame();
    runFrame("after_reset", '0, 8'h00, 8'h64, 1'b0, cap);
    for (int t = 0; t < 6; t++) begin
      runFrame($sformatf("rand%0d", t), randChannels(), 8'($urandom_range(0, 255)),
               8'($urandom_range(0, 255)), 1'b0, cap);
    end
    checkOutput("no_back_to_back_tx_send", consec_err, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errs);
    $finish;
  end

endmodule
